// File: rtl/dispatch_pkg.sv
// Shared types and encodings for the instruction dispatch controller.
// The optional branch-folding build is selected with DISPATCH_BRFOLD_EN.
package dispatch_pkg;

    typedef enum logic [2:0] {
        CLS_ARITH_I = 3'd0,
        CLS_MOV     = 3'd1,
        CLS_LDST    = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ARITH   = 3'd4,
        CLS_COMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } cls_e;

    typedef enum logic [1:0] {
        UNIT_EU  = 2'd0,
        UNIT_BIU = 2'd1,
        UNIT_FCU = 2'd2
    } unit_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RETIRE = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam logic [1:0] SEL_EU_ARITH_I  = 2'b00;
    localparam logic [1:0] SEL_EU_ARITH    = 2'b01;
    localparam logic [1:0] SEL_EU_COMP     = 2'b10;
    localparam logic [1:0] SEL_BIU_MOV     = 2'b00;
    localparam logic [1:0] SEL_BIU_LDST    = 2'b01;
    localparam logic [1:0] SEL_FCU_BRANCH  = 2'b00;

    localparam logic [1:0] RET_OK  = 2'b00;
    localparam logic [1:0] RET_ILL = 2'b01;
    localparam logic [1:0] RET_TMO = 2'b10;

    // Branch condition: 00 always, 01 flag[0], 10 flag[1], 11 never.
    function automatic logic br_taken(input logic [1:0] cond, input logic [1:0] flag);
        logic taken;
        case (cond)
            2'b00:   taken = 1'b1;
            2'b01:   taken = flag[0];
            2'b10:   taken = flag[1];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_classify.sv
// Combinational class decoder: leading-ones prefix code of the 6-bit class field
// mapped to instruction class, target unit and unit operation select.
module dispatch_ctrl_classify
    import dispatch_pkg::*;
(
    input  logic [5:0] c,
    output cls_e       cls,
    output unit_e      unit,
    output logic [1:0] sel
);

    // Prefix decode, MSB first.
    always_comb begin
        cls  = CLS_ILLEGAL;
        unit = UNIT_EU;
        sel  = 2'b00;
        casez (c)
            6'b0?????: begin cls = CLS_ARITH_I; unit = UNIT_EU;  sel = SEL_EU_ARITH_I; end
            6'b10????: begin cls = CLS_MOV;     unit = UNIT_BIU; sel = SEL_BIU_MOV;    end
            6'b110???: begin cls = CLS_LDST;    unit = UNIT_BIU; sel = SEL_BIU_LDST;   end
            6'b1110??: begin cls = CLS_BRANCH;  unit = UNIT_FCU; sel = SEL_FCU_BRANCH; end
            6'b11110?: begin cls = CLS_ARITH;   unit = UNIT_EU;  sel = SEL_EU_ARITH;   end
            6'b111110: begin cls = CLS_COMP;    unit = UNIT_EU;  sel = SEL_EU_COMP;    end
            default:   begin cls = CLS_ILLEGAL; unit = UNIT_EU;  sel = 2'b00;          end
        endcase
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Instruction dispatch controller: valid/ready intake, class decode, level req/ack
// to EU/BIU/FCU with per-unit timeout, retire pulse. Optional: DISPATCH_BRFOLD_EN.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int IR_W    = 32,
    parameter int CLS_MSB = 21,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ir_valid,
    output logic            ir_ready,
    input  logic [IR_W-1:0] ir,
    input  logic [1:0]      flag,
    output logic            cs_eu,
    output logic            cs_biu,
    output logic            cs_fcu,
    output logic [1:0]      sel_eu,
    output logic [1:0]      sel_biu,
    output logic            sel_fcu,
    input  logic            done_eu,
    input  logic            done_biu,
    input  logic            done_fcu,
    output logic            busy,
    output logic            retire_valid,
    output logic [1:0]      retire_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [2:0]      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    unit_e           unit_q, unit_d;
    logic            req_q, req_d;
    logic            cs_eu_q, cs_eu_d, cs_biu_q, cs_biu_d, cs_fcu_q, cs_fcu_d;
    logic [1:0]      sel_eu_q, sel_eu_d, sel_biu_q, sel_biu_d;
    logic            sel_fcu_q, sel_fcu_d;
    logic            ir_ready_q, ir_ready_d, busy_q, busy_d;
    logic            retire_valid_q, retire_valid_d;
    logic [1:0]      retire_err_q, retire_err_d;

    cls_e            cls_s;
    unit_e           unit_s;
    logic [1:0]      sel_s;
    logic            done_sel_s;
    logic            fold_s;
    logic            unused_s;

    dispatch_ctrl_classify u_classify (
        .c    (ir_q[CLS_MSB -: 6]),
        .cls  (cls_s),
        .unit (unit_s),
        .sel  (sel_s)
    );

`ifdef DISPATCH_BRFOLD_EN
    assign fold_s = (cls_s == CLS_BRANCH) && !br_taken(ir_q[CLS_MSB-6 -: 2], flag);
`else
    assign fold_s = 1'b0;
`endif

    // Only the class (and condition) bits of the latched word are consumed.
    assign unused_s = ^{ir_q, flag};

    // Acknowledge of the unit owning the current request; other units are ignored.
    always_comb begin
        case (unit_q)
            UNIT_EU:  done_sel_s = done_eu;
            UNIT_BIU: done_sel_s = done_biu;
            UNIT_FCU: done_sel_s = done_fcu;
            default:  done_sel_s = 1'b0;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        cnt_d          = cnt_q;
        unit_d         = unit_q;
        req_d          = req_q;
        cs_eu_d        = cs_eu_q;
        cs_biu_d       = cs_biu_q;
        cs_fcu_d       = cs_fcu_q;
        sel_eu_d       = sel_eu_q;
        sel_biu_d      = sel_biu_q;
        sel_fcu_d      = sel_fcu_q;
        retire_valid_d = 1'b0;
        retire_err_d   = RET_OK;
        case (state_q)
            ST_IDLE: begin
                if (ir_valid) begin
                    ir_d    = ir;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                cnt_d  = {TMO_W{1'b0}};
                unit_d = unit_s;
                if (cls_s == CLS_ILLEGAL) begin
                    req_d          = 1'b0;
                    retire_valid_d = 1'b1;
                    retire_err_d   = RET_ILL;
                    state_d        = ST_RETIRE;
                end else if (fold_s) begin
                    req_d          = 1'b0;
                    retire_valid_d = 1'b1;
                    retire_err_d   = RET_OK;
                    state_d        = ST_RETIRE;
                end else begin
                    req_d     = 1'b1;
                    cs_eu_d   = (unit_s == UNIT_EU);
                    cs_biu_d  = (unit_s == UNIT_BIU);
                    cs_fcu_d  = (unit_s == UNIT_FCU);
                    sel_eu_d  = (unit_s == UNIT_EU)  ? sel_s : 2'b00;
                    sel_biu_d = (unit_s == UNIT_BIU) ? sel_s : 2'b00;
                    sel_fcu_d = (unit_s == UNIT_FCU) ? sel_s[0] : 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving on the timeout edge still counts as success.
                if (done_sel_s || (cnt_q == TMO_LAST)) begin
                    cs_eu_d        = 1'b0;
                    cs_biu_d       = 1'b0;
                    cs_fcu_d       = 1'b0;
                    sel_eu_d       = 2'b00;
                    sel_biu_d      = 2'b00;
                    sel_fcu_d      = 1'b0;
                    retire_valid_d = 1'b1;
                    retire_err_d   = done_sel_s ? RET_OK : RET_TMO;
                    state_d        = ST_RETIRE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ST_RETIRE: begin
                if ((retire_err_q == RET_OK) && req_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!done_sel_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cs_eu_d   = 1'b0;
                cs_biu_d  = 1'b0;
                cs_fcu_d  = 1'b0;
                sel_eu_d  = 2'b00;
                sel_biu_d = 2'b00;
                sel_fcu_d = 1'b0;
            end
        endcase
        ir_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops every unit request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ir_q           <= {IR_W{1'b0}};
            cnt_q          <= {TMO_W{1'b0}};
            unit_q         <= UNIT_EU;
            req_q          <= 1'b0;
            cs_eu_q        <= 1'b0;
            cs_biu_q       <= 1'b0;
            cs_fcu_q       <= 1'b0;
            sel_eu_q       <= 2'b00;
            sel_biu_q      <= 2'b00;
            sel_fcu_q      <= 1'b0;
            ir_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_err_q   <= RET_OK;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            cnt_q          <= cnt_d;
            unit_q         <= unit_d;
            req_q          <= req_d;
            cs_eu_q        <= cs_eu_d;
            cs_biu_q       <= cs_biu_d;
            cs_fcu_q       <= cs_fcu_d;
            sel_eu_q       <= sel_eu_d;
            sel_biu_q      <= sel_biu_d;
            sel_fcu_q      <= sel_fcu_d;
            ir_ready_q     <= ir_ready_d;
            busy_q         <= busy_d;
            retire_valid_q <= retire_valid_d;
            retire_err_q   <= retire_err_d;
        end
    end

    assign ir_ready     = ir_ready_q;
    assign busy         = busy_q;
    assign cs_eu        = cs_eu_q;
    assign cs_biu       = cs_biu_q;
    assign cs_fcu       = cs_fcu_q;
    assign sel_eu       = sel_eu_q;
    assign sel_biu      = sel_biu_q;
    assign sel_fcu      = sel_fcu_q;
    assign retire_valid = retire_valid_q;
    assign retire_err   = retire_err_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Randomized bench for dispatch_ctrl against a transaction-level reference model
// (leading-ones class count, response-delay arithmetic for timing and error code).
module tb_dispatch_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_valid = 1'b0;
    logic [31:0] ir = 32'd0;
    logic [1:0]  flag = 2'b00;
    logic [2:0]  done_v = 3'b000;
    logic        ir_ready, cs_eu, cs_biu, cs_fcu, sel_fcu, busy, retire_valid;
    logic [1:0]  sel_eu, sel_biu, retire_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dispatch_ctrl #(.IR_W(32), .CLS_MSB(21), .TMO_W(8), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .flag(flag), .cs_eu(cs_eu), .cs_biu(cs_biu), .cs_fcu(cs_fcu),
        .sel_eu(sel_eu), .sel_biu(sel_biu), .sel_fcu(sel_fcu),
        .done_eu(done_v[0]), .done_biu(done_v[1]), .done_fcu(done_v[2]),
        .busy(busy), .retire_valid(retire_valid), .retire_err(retire_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] sel_of(input int u);
        case (u)
            0:       return sel_eu;
            1:       return sel_biu;
            default: return {1'b0, sel_fcu};
        endcase
    endfunction

    // One instruction: dly = cycles of cs seen before done is raised (-1 never),
    // rel = cycles after cs falls before done is released.
    task automatic run_txn(input string tag, input logic [31:0] instr, input int dly,
                           input int rel, input logic [1:0] fl);
        logic [5:0] c;
        logic [2:0] cs_v;
        int n_ones, unit, exp_sel, exp_err, exp_cs, exp_ret, exp_rdy;
        int cs_cnt, cs_first, ret_cnt, ret_n, ret_err, ready_n, foreign, sel_bad, busy_bad, drop_at;
        bit illegal, fold, ok;
        c = instr[21:16];
        n_ones = 0;
        for (int i = 5; i >= 0; i--) if (c[i] && n_ones == 5 - i) n_ones++;
        illegal = 1'b0; fold = 1'b0; unit = 0; exp_sel = 0;
        case (n_ones)
            0: begin unit = 0; exp_sel = 0; end
            1: begin unit = 1; exp_sel = 0; end
            2: begin unit = 1; exp_sel = 1; end
            3: begin unit = 2; exp_sel = 0; end
            4: begin unit = 0; exp_sel = 1; end
            5: begin unit = 0; exp_sel = 2; end
            default: illegal = 1'b1;
        endcase
`ifdef DISPATCH_BRFOLD_EN
        if (n_ones == 3)
            fold = !((instr[15:14] == 2'b00) || (instr[15:14] == 2'b01 && fl[0]) ||
                     (instr[15:14] == 2'b10 && fl[1]));
`endif
        cs_cnt = 0; cs_first = -1; ret_cnt = 0; ret_n = -1; ret_err = -1; ready_n = -1;
        foreign = 0; sel_bad = 0; busy_bad = 0; drop_at = -1;
        flag = fl; ir = instr; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0; ir = $urandom;
        chk({tag, "_acc_rdy"}, 32'(ir_ready), 32'd0);
        chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
        for (int n = 1; n <= 80; n++) begin
            tick();
            cs_v = {cs_fcu, cs_biu, cs_eu};
            for (int u = 0; u < 3; u++) begin
                if (cs_v[u] && (u != unit || illegal || fold)) foreign++;
                if (!cs_v[u] && sel_of(u) != 2'b00) sel_bad++;
            end
            if (!illegal && !fold && cs_v[unit]) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = n;
                if (sel_of(unit) != 2'(exp_sel)) sel_bad++;
            end
            if (retire_valid) begin ret_cnt++; ret_n = n; ret_err = int'(retire_err); end
            if (busy == ir_ready) busy_bad++;
            if (ir_ready) begin ready_n = n; break; end
            if (!illegal && !fold) begin
                if (done_v[unit] && !cs_v[unit]) begin
                    if (drop_at < 0) drop_at = n + rel;
                    if (n >= drop_at) done_v[unit] = 1'b0;
                end else if (dly >= 0 && cs_v[unit] && cs_cnt > dly) begin
                    done_v[unit] = 1'b1;
                end
            end
            for (int u = 0; u < 3; u++)
                if (u != unit || illegal || fold) done_v[u] = 1'($urandom_range(0, 1));
        end
        done_v = 3'b000;
        if (illegal || fold) begin
            exp_cs = 0; exp_ret = 1; exp_rdy = 2; exp_err = illegal ? 1 : 0;
        end else begin
            ok = (dly >= 0) && (dly <= TMO - 1);
            exp_cs  = ok ? dly + 1 : TMO;
            exp_ret = exp_cs + 1;
            exp_err = ok ? 0 : 2;
            exp_rdy = ok ? exp_ret + 1 + ((rel > 1) ? rel : 1) : exp_ret + 1;
            chk({tag, "_cs_first"}, cs_first, 32'd1);
        end
        chk({tag, "_ready_n"}, ready_n, exp_rdy);
        chk({tag, "_cs_cycles"}, cs_cnt, exp_cs);
        chk({tag, "_ret_cnt"}, ret_cnt, 32'd1);
        chk({tag, "_ret_n"}, ret_n, exp_ret);
        chk({tag, "_ret_err"}, ret_err, exp_err);
        chk({tag, "_foreign_cs"}, foreign, 32'd0);
        chk({tag, "_sel_bad"}, sel_bad, 32'd0);
        chk({tag, "_busy_bad"}, busy_bad, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [5:0]  c, r6, hi, lo;
        int          n;
        tick(); tick();
        chk("rst_cs", 32'({cs_eu, cs_biu, cs_fcu}), 32'd0);
        chk("rst_sel", 32'({sel_eu, sel_biu, sel_fcu}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_retire", 32'({retire_valid, retire_err}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(ir_ready), 32'd1);
        tick();

        run_txn("arith",   {10'd0, 6'b111100, 16'd0}, 0, 0, 2'b00);
        run_txn("ldst",    {10'd0, 6'b110000, 16'd0}, 4, 2, 2'b00);
        run_txn("comp_to", {10'd0, 6'b111110, 16'd0}, -1, 0, 2'b00);
        run_txn("comp_ok", {10'd0, 6'b111110, 16'd0}, TMO - 1, 1, 2'b00);
        run_txn("illegal", {10'd0, 6'b111111, 16'd0}, 0, 0, 2'b00);
        run_txn("branch",  {10'd0, 6'b111000, 16'd0}, 1, 0, 2'b00);

        // Reset while a MOV waits on the BIU.
        ir = {10'd0, 6'b100000, 16'd0}; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick(); tick();
        chk("mrst_cs_before", 32'(cs_biu), 32'd1);
        #2;
        rst_n = 1'b0; done_v[1] = 1'b1;
        #1;
        chk("mrst_cs_async", 32'(cs_biu), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_retire", 32'(retire_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_ready", 32'(ir_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_done", 32'({busy, cs_biu, retire_valid, ir_ready}), 32'd1);
        end
        done_v = 3'b000;
        tick();

        for (int t = 0; t < 40; t++) begin
            w  = $urandom;
            r6 = 6'($urandom);
            n  = $urandom_range(0, 6);
            hi = 6'h3f << (6 - n);
            lo = 6'h3f >> (n + 1);
            c  = hi | (r6 & lo);
            w[21:16] = c;
            run_txn($sformatf("rnd%0d", t), w, $urandom_range(0, TMO + 2) - 1,
                    $urandom_range(0, 3), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
